// File: rtl/vram_arb_pkg.sv
// Shared definitions for the CPU/VPU shared-RAM arbiter.
// Holds the arbiter state encoding, register window addresses and counter widths.
// Imported by vram_arbiter; no logic of its own.
package vram_arb_pkg;

  // Encoding is visible to software through status register bits [1:0].
  typedef enum logic [1:0] {
    ARB_CPU  = 2'd0,
    ARB_HREQ = 2'd1,
    ARB_VPU  = 2'd2,
    ARB_TURN = 2'd3
  } arb_state_e;

  localparam logic [1:0] REG_STATUS    = 2'd0;
  localparam logic [1:0] REG_STOLEN_LO = 2'd1;
  localparam logic [1:0] REG_STOLEN_HI = 2'd2;
  localparam logic [1:0] REG_MAX_LAT   = 2'd3;

  localparam int STOLEN_W = 16;
  localparam int LAT_W    = 8;
  localparam int TURN_W   = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk_i/rst_i (sync active-high), clr_i (wins over inc_i), inc_i,
//        cnt_o current count, sat_o high when the count is all ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign sat_o = &cnt_q;
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shared-RAM arbiter: halts the CPU on a VPU DMA request, grants the RAM to the VPU,
// registers VPU read data, then returns the bus after a turnaround.
// Ports: CPU bus (cpu_*), VPU DMA (vpu_*), RAM (ram_*), register window (cs/rw/ad/di/do).
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW   = 16,
  parameter int TURN = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cs_i,
  input  logic          rw_i,
  input  logic [1:0]    ad_i,
  input  logic [7:0]    di_i,
  output logic [7:0]    do_o,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [7:0]    cpu_dout_i,
  output logic [7:0]    cpu_din_o,
  input  logic          cpu_rw_i,
  input  logic          cpu_vma_i,
  output logic          cpu_halt_o,
  input  logic          cpu_ba_i,
  input  logic          vpu_hold_i,
  input  logic          vpu_cs_i,
  input  logic [AW-1:0] vpu_addr_i,
  output logic [7:0]    vpu_data_o,
  output logic          vpu_grant_o,
  output logic [AW-1:0] ram_addr_o,
  input  logic [7:0]    ram_rdata_i,
  output logic [7:0]    ram_wdata_o,
  output logic          ram_we_o,
  output logic          ram_oe_o
);

  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN - 1);

  arb_state_e          state_q;
  logic                cpu_halt_q;
  logic                vpu_grant_q;
  logic [TURN_W-1:0]   turn_cnt_q;
  logic [AW-1:0]       ram_addr_q;
  logic [7:0]          vpu_data_q;
  logic [7:0]          do_q;
  logic [7:0]          shadow_q;
  logic [7:0]          max_lat_q;

  logic [STOLEN_W-1:0] stolen_cnt;
  logic                stolen_sat;
  logic [LAT_W-1:0]    lat_cnt;
  logic                lat_sat;
  logic [LAT_W-1:0]    lat_now;
  logic                hreq_exit;
  logic                reg_rd;
  logic                reg_wr;
  logic [7:0]          status;

  // ---------------------------------------------------------------------------
  // Arbiter FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_CPU;
      cpu_halt_q  <= 1'b0;
      vpu_grant_q <= 1'b0;
      turn_cnt_q  <= '0;
    end else begin
      case (state_q)
        ARB_CPU: begin
          if (vpu_hold_i) begin
            state_q    <= ARB_HREQ;
            cpu_halt_q <= 1'b1;
          end
        end
        ARB_HREQ: begin
          // A requester that has gone away is not granted, even if BA lands now.
          if (!vpu_hold_i) begin
            state_q    <= ARB_CPU;
            cpu_halt_q <= 1'b0;
          end else if (cpu_ba_i) begin
            state_q     <= ARB_VPU;
            vpu_grant_q <= 1'b1;
          end
        end
        ARB_VPU: begin
          if (!vpu_hold_i) begin
            state_q     <= ARB_TURN;
            vpu_grant_q <= 1'b0;
            turn_cnt_q  <= TURN_LOAD;
          end
        end
        ARB_TURN: begin
          // Always lands in CPU, so a re-request waits one unhalted CPU cycle.
          if (turn_cnt_q == '0) begin
            state_q    <= ARB_CPU;
            cpu_halt_q <= 1'b0;
          end else begin
            turn_cnt_q <= turn_cnt_q - 1'b1;
          end
        end
        default: state_q <= ARB_CPU;
      endcase
    end
  end

  assign cpu_halt_o  = cpu_halt_q;
  assign vpu_grant_o = vpu_grant_q;

  // ---------------------------------------------------------------------------
  // RAM muxes
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_addr_o  = cpu_addr_i;
    ram_wdata_o = cpu_dout_i;
    ram_we_o    = 1'b0;
    ram_oe_o    = 1'b0;
    case (state_q)
      ARB_CPU, ARB_HREQ: begin
        ram_we_o = cpu_vma_i & ~cpu_rw_i;
        ram_oe_o = cpu_vma_i & cpu_rw_i;
      end
      ARB_VPU: begin
        ram_addr_o = vpu_addr_i;
        ram_oe_o   = vpu_cs_i;
      end
      default: begin
        ram_addr_o = ram_addr_q;
      end
    endcase
  end

  assign cpu_din_o = ram_rdata_i;

  // ram_addr_q remembers the last driven address so TURN keeps the bus quiet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ram_addr_q <= '0;
      vpu_data_q <= 8'h00;
    end else begin
      if (state_q != ARB_TURN) begin
        ram_addr_q <= ram_addr_o;
      end
      if (state_q == ARB_VPU && vpu_cs_i) begin
        vpu_data_q <= ram_rdata_i;
      end
    end
  end

  assign vpu_data_o = vpu_data_q;

  // ---------------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------------
  assign reg_rd = cs_i & rw_i;
  assign reg_wr = cs_i & ~rw_i;

  sat_counter #(.W(STOLEN_W)) u_stolen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (reg_wr && ad_i == REG_STOLEN_LO),
    .inc_i (cpu_halt_q & ~stolen_sat),
    .cnt_o (stolen_cnt),
    .sat_o (stolen_sat)
  );

  // Per-request latency restarts whenever the FSM is outside HREQ.
  sat_counter #(.W(LAT_W)) u_latency (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (state_q != ARB_HREQ),
    .inc_i (state_q == ARB_HREQ),
    .cnt_o (lat_cnt),
    .sat_o (lat_sat)
  );

  assign hreq_exit = (state_q == ARB_HREQ) && (cpu_ba_i || !vpu_hold_i);
  // The counter has not yet seen the exit cycle itself, so add it here.
  assign lat_now   = lat_sat ? '1 : lat_cnt + 1'b1;

  // ---------------------------------------------------------------------------
  // Register window
  // ---------------------------------------------------------------------------
  assign status = {4'b0000, vpu_grant_q, cpu_halt_q, state_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      do_q      <= 8'h00;
      shadow_q  <= 8'h00;
      max_lat_q <= 8'h00;
    end else begin
      if (reg_rd) begin
        case (ad_i)
          REG_STATUS:    do_q <= status;
          REG_STOLEN_LO: begin
            // Snapshot the high byte so a following read of reg 2 is coherent.
            do_q     <= stolen_cnt[7:0];
            shadow_q <= stolen_cnt[15:8];
          end
          REG_STOLEN_HI: do_q <= shadow_q;
          default:       do_q <= max_lat_q;
        endcase
      end
      if (reg_wr && ad_i == REG_STOLEN_HI) begin
        shadow_q <= 8'h00;
      end
      if (reg_wr && ad_i == REG_MAX_LAT) begin
        max_lat_q <= 8'h00;
      end else if (hreq_exit && lat_now > max_lat_q) begin
        max_lat_q <= lat_now;
      end
    end
  end

  assign do_o = do_q;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b0;
  logic          rw = 1'b1;
  logic [1:0]    ad = 2'd0;
  logic [7:0]    di = 8'h00;
  logic [7:0]    do_o;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_dout = 8'h00;
  logic [7:0]    cpu_din;
  logic          cpu_rw = 1'b1;
  logic          cpu_vma = 1'b0;
  logic          cpu_halt;
  logic          cpu_ba = 1'b0;
  logic          vpu_hold = 1'b0;
  logic          vpu_cs = 1'b0;
  logic [AW-1:0] vpu_addr = '0;
  logic [7:0]    vpu_data;
  logic          vpu_grant;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rdata = 8'h00;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic          ram_oe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.AW(AW), .TURN(1)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cs_i        (cs),
    .rw_i        (rw),
    .ad_i        (ad),
    .di_i        (di),
    .do_o        (do_o),
    .cpu_addr_i  (cpu_addr),
    .cpu_dout_i  (cpu_dout),
    .cpu_din_o   (cpu_din),
    .cpu_rw_i    (cpu_rw),
    .cpu_vma_i   (cpu_vma),
    .cpu_halt_o  (cpu_halt),
    .cpu_ba_i    (cpu_ba),
    .vpu_hold_i  (vpu_hold),
    .vpu_cs_i    (vpu_cs),
    .vpu_addr_i  (vpu_addr),
    .vpu_data_o  (vpu_data),
    .vpu_grant_o (vpu_grant),
    .ram_addr_o  (ram_addr),
    .ram_rdata_i (ram_rdata),
    .ram_wdata_o (ram_wdata),
    .ram_we_o    (ram_we),
    .ram_oe_o    (ram_oe)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; ad = a;
    tick();
    d  = do_o;
    cs = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] v);
    cs = 1'b1; rw = 1'b0; ad = a; di = v;
    tick();
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", cpu_halt); end
    checks++; if (vpu_grant !== 1'b0) begin errors++; $display("FAIL reset_grant got %b want 0", vpu_grant); end
    checks++; if (vpu_data !== 8'h00) begin errors++; $display("FAIL reset_vpu_data got %h want 00", vpu_data); end
    checks++; if (do_o !== 8'h00) begin errors++; $display("FAIL reset_do got %h want 00", do_o); end
  endtask

  task automatic test_idle();
    cpu_vma = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h1234; cpu_dout = 8'h5A;
    #1;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL idle_we got %b want 1", ram_we); end
    checks++; if (ram_oe !== 1'b0) begin errors++; $display("FAIL idle_oe got %b want 0", ram_oe); end
    checks++; if (ram_addr !== 16'h1234) begin errors++; $display("FAIL idle_addr got %h want 1234", ram_addr); end
    checks++; if (ram_wdata !== 8'h5A) begin errors++; $display("FAIL idle_wdata got %h want 5a", ram_wdata); end
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL idle_halt got %b want 0", cpu_halt); end
    cpu_rw = 1'b1; ram_rdata = 8'h3C;
    #1;
    checks++; if (ram_oe !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL idle_read_strobes got oe=%b we=%b want oe=1 we=0", ram_oe, ram_we); end
    checks++; if (cpu_din !== 8'h3C) begin errors++; $display("FAIL idle_cpu_din got %h want 3c", cpu_din); end
    cpu_rw = 1'b0;
  endtask

  task automatic test_grant();
    logic [7:0] d;
    vpu_hold = 1'b1; cpu_ba = 1'b1;
    tick();
    checks++; if (cpu_halt !== 1'b1 || vpu_grant !== 1'b0) begin errors++; $display("FAIL grant_hreq got halt=%b grant=%b want 1 0", cpu_halt, vpu_grant); end
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL grant_hreq_cpu_we got %b want 1", ram_we); end
    tick();
    checks++; if (vpu_grant !== 1'b1) begin errors++; $display("FAIL grant_vpu got %b want 1", vpu_grant); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL grant_we_blocked got %b want 0", ram_we); end
    vpu_cs = 1'b1; vpu_addr = 16'h8000; ram_rdata = 8'hA5;
    #1;
    checks++; if (ram_addr !== 16'h8000 || ram_oe !== 1'b1) begin errors++; $display("FAIL grant_ram got addr=%h oe=%b want 8000 1", ram_addr, ram_oe); end
    tick();
    checks++; if (vpu_data !== 8'hA5) begin errors++; $display("FAIL grant_vpu_data got %h want a5", vpu_data); end
    vpu_cs = 1'b0; ram_rdata = 8'h00;
    tick();
    checks++; if (vpu_data !== 8'hA5 || ram_oe !== 1'b0) begin errors++; $display("FAIL grant_hold got data=%h oe=%b want a5 0", vpu_data, ram_oe); end
    reg_read(2'd0, d);
    checks++; if (d !== 8'h0E) begin errors++; $display("FAIL grant_status got %h want 0e", d); end
  endtask

  task automatic test_release();
    vpu_hold = 1'b0;
    tick();
    checks++; if (vpu_grant !== 1'b0 || cpu_halt !== 1'b1) begin errors++; $display("FAIL rel_turn got grant=%b halt=%b want 0 1", vpu_grant, cpu_halt); end
    checks++; if (ram_we !== 1'b0 || ram_oe !== 1'b0) begin errors++; $display("FAIL rel_turn_quiet got we=%b oe=%b want 0 0", ram_we, ram_oe); end
    checks++; if (ram_addr !== 16'h8000) begin errors++; $display("FAIL rel_turn_addr got %h want 8000", ram_addr); end
    tick();
    checks++; if (cpu_halt !== 1'b0 || ram_we !== 1'b1 || ram_addr !== 16'h1234) begin errors++; $display("FAIL rel_cpu got halt=%b we=%b addr=%h want 0 1 1234", cpu_halt, ram_we, ram_addr); end
    vpu_hold = 1'b1;
    tick(); tick();
    checks++; if (vpu_grant !== 1'b1) begin errors++; $display("FAIL rel_regrant got %b want 1", vpu_grant); end
    vpu_hold = 1'b0;
    tick();
    vpu_hold = 1'b1;
    tick();
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL rel_gap_cycle got halt=%b want 0", cpu_halt); end
    tick();
    checks++; if (cpu_halt !== 1'b1 || vpu_grant !== 1'b0) begin errors++; $display("FAIL rel_rehreq got halt=%b grant=%b want 1 0", cpu_halt, vpu_grant); end
    tick();
    checks++; if (vpu_grant !== 1'b1) begin errors++; $display("FAIL rel_rehreq_grant got %b want 1", vpu_grant); end
    vpu_hold = 1'b0;
    tick(); tick();
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL rel_final got halt=%b want 0", cpu_halt); end
    cpu_ba = 1'b0;
  endtask

  task automatic test_abort();
    logic [7:0] d;
    reg_write(2'd3, 8'h00);
    reg_read(2'd3, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL abort_clear_max got %h want 00", d); end
    vpu_hold = 1'b1; cpu_ba = 1'b0;
    tick();
    checks++; if (cpu_halt !== 1'b1 || vpu_grant !== 1'b0) begin errors++; $display("FAIL abort_hreq got halt=%b grant=%b want 1 0", cpu_halt, vpu_grant); end
    vpu_hold = 1'b0;
    tick();
    checks++; if (cpu_halt !== 1'b0 || vpu_grant !== 1'b0) begin errors++; $display("FAIL abort_back got halt=%b grant=%b want 0 0", cpu_halt, vpu_grant); end
    tick();
    checks++; if (vpu_grant !== 1'b0) begin errors++; $display("FAIL abort_no_grant got %b want 0", vpu_grant); end
    reg_read(2'd3, d);
    checks++; if ($isunknown(d) || d < 8'd1) begin errors++; $display("FAIL abort_latency got %h want >=01", d); end
  endtask

  task automatic test_stats();
    logic [7:0] d;
    reg_write(2'd1, 8'h00);
    // 299 edges with hold high, then VPU->TURN and TURN->CPU: 300 halted edges.
    cpu_ba = 1'b1; vpu_hold = 1'b1;
    repeat (299) tick();
    vpu_hold = 1'b0;
    tick(); tick();
    checks++; if (cpu_halt !== 1'b0) begin errors++; $display("FAIL stats_released got halt=%b want 0", cpu_halt); end
    reg_read(2'd1, d);
    checks++; if (d !== 8'h2C) begin errors++; $display("FAIL stats_lo got %h want 2c", d); end
    reg_read(2'd2, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL stats_hi got %h want 01", d); end
    reg_write(2'd1, 8'hFF);
    reg_read(2'd1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL stats_clear_lo got %h want 00", d); end
    reg_read(2'd2, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL stats_clear_hi got %h want 00", d); end
    // Clear while halted must beat that cycle's increment: 0, then +2 on release.
    vpu_hold = 1'b1;
    tick(); tick();
    reg_write(2'd1, 8'h00);
    vpu_hold = 1'b0;
    tick(); tick();
    reg_read(2'd1, d);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL stats_clear_wins got %h want 02", d); end
    vpu_hold = 1'b1;
    repeat (65600) tick();
    vpu_hold = 1'b0;
    tick(); tick();
    reg_read(2'd1, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL stats_sat_lo got %h want ff", d); end
    reg_read(2'd2, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL stats_sat_hi got %h want ff", d); end
    // BA arrives so that HREQ lasts exactly 5 cycles.
    cpu_ba = 1'b0;
    reg_write(2'd3, 8'h00);
    vpu_hold = 1'b1;
    tick();
    repeat (4) tick();
    checks++; if (vpu_grant !== 1'b0 || cpu_halt !== 1'b1) begin errors++; $display("FAIL stats_wait_ba got grant=%b halt=%b want 0 1", vpu_grant, cpu_halt); end
    cpu_ba = 1'b1;
    tick();
    checks++; if (vpu_grant !== 1'b1) begin errors++; $display("FAIL stats_late_grant got %b want 1", vpu_grant); end
    vpu_hold = 1'b0; cpu_ba = 1'b0;
    tick(); tick();
    reg_read(2'd3, d);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL stats_max_lat got %h want 05", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    vpu_hold = 1'b1; cpu_ba = 1'b1;
    vpu_cs = 1'b1; ram_rdata = 8'h77;
    tick(); tick();
    checks++; if (vpu_grant !== 1'b1) begin errors++; $display("FAIL rstmid_grant got %b want 1", vpu_grant); end
    tick();
    rst = 1'b1; vpu_hold = 1'b0; cpu_ba = 1'b0; vpu_cs = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if (cpu_halt !== 1'b0 || vpu_grant !== 1'b0) begin errors++; $display("FAIL rstmid_drop got halt=%b grant=%b want 0 0", cpu_halt, vpu_grant); end
    checks++; if (vpu_data !== 8'h00) begin errors++; $display("FAIL rstmid_vpu_data got %h want 00", vpu_data); end
    for (int a = 0; a < 4; a++) begin
      reg_read(2'(a), d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL rstmid_reg%0d got %h want 00", a, d); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_grant();
    test_release();
    test_abort();
    test_stats();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
